// File: rtl/spike_rate_monitor_pkg.sv
// Shared constants and state types for the spike rate monitor.
// Channel map: bit 0 is the final spike, bits 1..3 are hidden neurons 1..3.
package spike_rate_monitor_pkg;

    localparam int CH_FINAL = 0;
    localparam int CH_N1    = 1;
    localparam int CH_N2    = 2;
    localparam int CH_N3    = 3;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 16;

    typedef enum logic {
        CNT_IDLE,
        CNT_COUNT
    } cnt_state_e;

    typedef enum logic {
        DMP_EMPTY,
        DMP_DUMP
    } dump_state_e;

endpackage

// File: rtl/spike_rate_monitor_sat_counter.sv
// Per-channel saturating spike counter with synchronous clear.
// ovf_o strobes when a spike arrives while the counter already sits at max.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] next_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        if (en_i && inc_i) begin
            if (cnt_q == MAX) begin
                ovf_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // next_o includes this cycle's spike so the window end can snapshot it
    assign next_o = cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spike_rate_monitor.sv
// Windowed per-channel spike counter with a snapshot buffer that is
// streamed out one channel per beat over a valid/ready handshake.
module spike_rate_monitor
    import spike_rate_monitor_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         spike_in,
    input  logic                    enable,
    input  logic [WIN_W-1:0]        window_len,
    input  logic                    clear_flags,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [$clog2(N_CH)-1:0] rd_channel,
    output logic [CNT_W-1:0]        rd_count,
    output logic                    window_tick,
    output logic [N_CH-1:0]         overflow,
    output logic                    dropped
);

    localparam int CH_W = $clog2(N_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    cnt_state_e  state_q, state_d;
    dump_state_e dstate_q, dstate_d;

    logic [WIN_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] len_eff;

    logic [N_CH-1:0][CNT_W-1:0] cnt_next;
    logic [N_CH-1:0][CNT_W-1:0] snap_q, snap_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [N_CH-1:0]            ovf_set;
    logic [N_CH-1:0]            ovf_q, ovf_d;
    logic                       drop_q, drop_d;

    logic run;
    logic last;
    logic xfer;
    logic fin;
    logic load;
    logic drop_set;

    assign len_eff = (window_len == '0) ? WIN_W'(1) : window_len;
    assign run     = (state_q == CNT_COUNT) && enable;
    assign last    = run && (win_q == len_q - 1'b1);

    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i   (clk),
            .reset_i (reset),
            .en_i    (run),
            .inc_i   (spike_in[i]),
            .clr_i   (!run || last),
            .next_o  (cnt_next[i]),
            .ovf_o   (ovf_set[i])
        );
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        win_d   = win_q;
        unique case (state_q)
            CNT_IDLE: begin
                if (enable) begin
                    state_d = CNT_COUNT;
                    len_d   = len_eff;
                    win_d   = '0;
                end
            end
            CNT_COUNT: begin
                if (!enable) begin
                    state_d = CNT_IDLE;
                    win_d   = '0;
                end else if (last) begin
                    len_d = len_eff;
                    win_d = '0;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            default: state_d = CNT_IDLE;
        endcase
    end

    // The buffer is free when empty or when its last word leaves this cycle
    assign xfer     = (dstate_q == DMP_DUMP) && rd_ready;
    assign fin      = xfer && (ch_q == LAST_CH);
    assign load     = last && ((dstate_q == DMP_EMPTY) || fin);
    assign drop_set = last && !load;

    always_comb begin
        dstate_d = dstate_q;
        ch_d     = ch_q;
        snap_d   = snap_q;
        unique case (dstate_q)
            DMP_EMPTY: begin
                if (load) begin
                    dstate_d = DMP_DUMP;
                    ch_d     = '0;
                    snap_d   = cnt_next;
                end
            end
            DMP_DUMP: begin
                if (load) begin
                    ch_d   = '0;
                    snap_d = cnt_next;
                end else if (fin) begin
                    dstate_d = DMP_EMPTY;
                    ch_d     = '0;
                end else if (xfer) begin
                    ch_d = ch_q + 1'b1;
                end
            end
            default: dstate_d = DMP_EMPTY;
        endcase
    end

    assign ovf_d  = (clear_flags ? '0 : ovf_q) | ovf_set;
    assign drop_d = (clear_flags ? 1'b0 : drop_q) | drop_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CNT_IDLE;
            dstate_q <= DMP_EMPTY;
            len_q    <= WIN_W'(1);
            win_q    <= '0;
            snap_q   <= '0;
            ch_q     <= '0;
            ovf_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dstate_q <= dstate_d;
            len_q    <= len_d;
            win_q    <= win_d;
            snap_q   <= snap_d;
            ch_q     <= ch_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    assign rd_valid    = (dstate_q == DMP_DUMP);
    assign rd_channel  = ch_q;
    assign rd_count    = rd_valid ? snap_q[ch_q] : '0;
    assign window_tick = last;
    assign overflow    = ovf_q;
    assign dropped     = drop_q;

endmodule

// File: doc/spike_rate_monitor.md
Name: spike_rate_monitor

Overview:
- Downstream consumer of the LIF network spike outputs: the three hidden-neuron spikes and the final spike.
- Counts spikes per channel over a programmable window and snapshots the counts at window end.
- Streams the snapshot out one channel per beat over a valid/ready handshake.
- Converts single-cycle spike trains into rate-coded words for off-chip readout or a downstream classifier stage.

Parameters:
- N_CH, 4, number of spike channels monitored (bit 0 = final spike, bits 1..3 = neurons 1..3)
- CNT_W, 8, per-channel spike counter width; counts saturate at 2^CNT_W-1
- WIN_W, 16, width of the window-length field

Ports:
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- spike_in  in  N_CH  one-cycle spike pulses, one bit per channel, sampled every clk
- enable  in  1  1 = run windows continuously; 0 = idle, counters held at 0
- window_len  in  WIN_W  window length in cycles, sampled at window start; 0 treated as 1
- clear_flags  in  1  one-cycle pulse that clears the sticky overflow and dropped flags
- rd_valid  out  1  snapshot word available
- rd_ready  in  1  consumer accepts the word
- rd_channel  out  $clog2(N_CH)  channel index of the current word
- rd_count  out  CNT_W  spike count of that channel for the completed window
- window_tick  out  1  one-cycle pulse on the last cycle of each completed window
- overflow  out  N_CH  sticky; channel counter saturated in some window
- dropped  out  1  sticky; a completed window was discarded because the previous dump was unfinished

Behaviour:
- Reset: counters, window counter, snapshot and flags = 0; rd_valid=0, rd_channel=0, rd_count=0, window_tick=0; state IDLE.
- Counting FSM states:
  - IDLE: counters 0. enable=1 → COUNT next cycle; window_len latched, window counter = 0.
  - COUNT: each cycle, cnt[i] += spike_in[i], saturating at max. Saturation sets overflow[i], sticky.
  - On the cycle where window counter == latched_len-1 (last cycle):
    - That cycle's spikes are included in the counts.
    - Final counts are copied to the snapshot if the buffer is free.
    - Counters and window counter clear; window_len is re-latched.
    - window_tick=1 for exactly this cycle.
    - Counting continues with no dead cycle.
  - enable=0 in COUNT: window aborted, counters cleared, no snapshot, no tick → IDLE. Any pending dump still completes.
- Dump path (independent of the counting FSM):
  - States EMPTY and DUMP. Snapshot load → DUMP with rd_valid=1 on the next cycle, rd_channel=0.
  - Transfer occurs when rd_valid && rd_ready. rd_channel advances 0..N_CH-1.
  - rd_channel and rd_count stay stable while rd_valid=1 && rd_ready=0.
  - Transfer of channel N_CH-1 → EMPTY, rd_valid=0 the next cycle.
  - A window end coinciding with that final transfer loads the new snapshot (buffer counts as free), and rd_valid stays 1 with channel 0.
  - Window end while DUMP is otherwise busy: new counts discarded, dropped set sticky, current dump untouched.
- Latency: the window's last spike reaches rd_count 1 cycle after window_tick.
- Flags: clear_flags clears overflow and dropped. If set and clear coincide, set wins.
- Reset mid-dump or mid-window: everything returns to reset values next cycle; no partial words.

Decomposition:
- Shared package holds:
  - channel index map constants (CH_FINAL=0, CH_N1=1, CH_N2=2, CH_N3=3)
  - defaults for CNT_W and WIN_W
  - enum typedefs for the counting states (IDLE, COUNT) and dump states (EMPTY, DUMP)
- One sub-module is natural: sat_counter. It is a per-channel saturating incrementer with synchronous clear and an overflow strobe, instantiated N_CH times.

Test Plan:
1. Basic window: window_len=10, enable=1, rd_ready=1; ch0 spikes every cycle, ch1 every other cycle, ch2 never, ch3 on cycles 2, 5, 9 → window_tick on cycle 9; words (0,10),(1,5),(2,0),(3,3) on 4 consecutive cycles starting next cycle.
2. Saturation: CNT_W=8, window_len=300, ch0 constantly high → rd_count=255 for ch0, overflow[0]=1. clear_flags pulse → overflow=0.
3. Backpressure/drop: window_len=5, rd_ready=0 for 15 cycles → first snapshot held with rd_channel=0 stable; windows 2 and 3 dropped, dropped=1. Releasing rd_ready yields window-1 counts only.
4. Abort: window_len=20, 7 spikes on ch1, enable dropped at cycle 12 → no window_tick, no rd_valid; re-enable restarts the count from 0.
5. Back-to-back: window_len=4 with rd_ready=1 → dump finishes exactly as the next window ends; no drop, rd_valid continuously high across the windows.
6. Reset mid-dump: assert reset while rd_channel=2 → next cycle rd_valid=0, rd_channel=0, all counts and flags 0.
